// File: rtl/byte_ser_pkg.sv
// Shared types for the byte serializer:
// FSM states, beat index and frame trailer.
package byte_ser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    CSUM
  } state_e;

  typedef logic [1:0] beat_idx_t;

  localparam logic [1:0] TRAILER = 2'b11;

endpackage

// File: rtl/byte_serializer.sv
// Serializes a four-byte packed word onto a
// valid/ready byte stream with optional XOR checksum.
module byte_serializer
  import byte_ser_pkg::*;
#(
  parameter int BYTE_W      = 8,
  parameter bit CHECKSUM_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_1,
  input  logic [BYTE_W-1:0] in_2,
  input  logic [BYTE_W-1:0] in_3,
  input  logic [BYTE_W-1:0] in_4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  output logic              marker_err,
  output logic [7:0]        frame_count
);

  state_e            state_q, state_d;
  beat_idx_t         idx_q, idx_d;
  beat_idx_t         idx_nxt;
  logic [BYTE_W-1:0] hold_q [4];
  logic [BYTE_W-1:0] csum;
  logic [BYTE_W-1:0] data_d;
  logic              valid_d;
  logic              last_d;
  logic              take;
  logic              fin;
  logic              accept;
  logic              end_frame;
  logic              marker_bad;

  assign csum = hold_q[0] ^ hold_q[1]
              ^ hold_q[2] ^ hold_q[3];

  assign take   = out_valid && out_ready;
  assign fin    = take && out_last;
  assign in_ready = !reset &&
                    (state_q == IDLE || fin);
  assign accept = in_valid && in_ready;

  assign idx_nxt    = idx_q + 2'd1;
  assign marker_bad = in_4[1:0] != TRAILER;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    valid_d   = out_valid;
    data_d    = out_data;
    last_d    = out_last;
    end_frame = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      SEND: begin
        if (take) begin
          if (idx_q == 2'd3) begin
            if (CHECKSUM_EN) begin
              state_d = CSUM;
              data_d  = csum;
              last_d  = 1'b1;
            end else begin
              end_frame = 1'b1;
            end
          end else begin
            idx_d  = idx_nxt;
            data_d = hold_q[idx_nxt];
            last_d = !CHECKSUM_EN &&
                     (idx_nxt == 2'd3);
          end
        end
      end
      CSUM: begin
        if (take) end_frame = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A word accepted on the final-beat cycle
    // starts the next frame with no bubble.
    if (state_q == IDLE || end_frame) begin
      if (accept) begin
        state_d = SEND;
        idx_d   = 2'd0;
        valid_d = 1'b1;
        data_d  = in_1;
        last_d  = 1'b0;
      end else begin
        state_d = IDLE;
        idx_d   = 2'd0;
        valid_d = 1'b0;
        data_d  = '0;
        last_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      marker_err  <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid   <= valid_d;
      out_data    <= data_d;
      out_last    <= last_d;
      marker_err  <= accept && marker_bad;
      if (end_frame)
        frame_count <= frame_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hold_q[0] <= in_1;
      hold_q[1] <= in_2;
      hold_q[2] <= in_3;
      hold_q[3] <= in_4;
    end
  end

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench: checksum and no-checksum instances
// driven from one linear stimulus sequence.
module tb_byte_serializer;

  logic       clk;
  logic       reset;

  logic       in_valid_a, in_ready_a;
  logic [7:0] a1, a2, a3, a4;
  logic       out_valid_a, out_ready_a;
  logic [7:0] out_data_a;
  logic       out_last_a, marker_err_a;
  logic [7:0] frame_count_a;

  logic       in_valid_b, in_ready_b;
  logic [7:0] b1, b2, b3, b4;
  logic       out_valid_b, out_ready_b;
  logic [7:0] out_data_b;
  logic       out_last_b, marker_err_b;
  logic [7:0] frame_count_b;

  int passed = 0;
  int total  = 0;

  byte_serializer #(
    .BYTE_W(8), .CHECKSUM_EN(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_1(a1), .in_2(a2), .in_3(a3), .in_4(a4),
    .out_valid(out_valid_a),
    .out_ready(out_ready_a),
    .out_data(out_data_a), .out_last(out_last_a),
    .marker_err(marker_err_a),
    .frame_count(frame_count_a)
  );

  byte_serializer #(
    .BYTE_W(8), .CHECKSUM_EN(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_1(b1), .in_2(b2), .in_3(b3), .in_4(b4),
    .out_valid(out_valid_b),
    .out_ready(out_ready_b),
    .out_data(out_data_b), .out_last(out_last_b),
    .marker_err(marker_err_b),
    .frame_count(frame_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic beat_a(input string tag,
                        input logic [7:0] d,
                        input logic l);
    chk({tag, "_valid"}, 8'(out_valid_a), 8'h1);
    chk({tag, "_data"}, out_data_a, d);
    chk({tag, "_last"}, 8'(out_last_a), 8'(l));
  endtask

  task automatic beat_b(input string tag,
                        input logic [7:0] d,
                        input logic l);
    chk({tag, "_valid"}, 8'(out_valid_b), 8'h1);
    chk({tag, "_data"}, out_data_b, d);
    chk({tag, "_last"}, 8'(out_last_b), 8'(l));
  endtask

  task automatic send_frame_a();
    a1 = 8'hA5; a2 = 8'h3C; a3 = 8'h0F; a4 = 8'hF3;
    in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    repeat (5) step();
  endtask

  initial begin
    reset = 1'b1;
    in_valid_a = 1'b0; out_ready_a = 1'b1;
    in_valid_b = 1'b0; out_ready_b = 1'b1;
    a1 = 8'h0; a2 = 8'h0; a3 = 8'h0; a4 = 8'h0;
    b1 = 8'h0; b2 = 8'h0; b3 = 8'h0; b4 = 8'h0;
    step();
    step();
    chk("rst_valid", 8'(out_valid_a), 8'h0);
    chk("rst_data", out_data_a, 8'h00);
    chk("rst_last", 8'(out_last_a), 8'h0);
    chk("rst_marker", 8'(marker_err_a), 8'h0);
    chk("rst_count", frame_count_a, 8'h00);
    chk("rst_in_ready", 8'(in_ready_a), 8'h0);
    reset = 1'b0;
    #1;
    chk("idle_in_ready", 8'(in_ready_a), 8'h1);

    // basic frame with checksum
    a1 = 8'hA5; a2 = 8'h3C; a3 = 8'h0F; a4 = 8'hF3;
    in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    beat_a("basic0", 8'hA5, 1'b0);
    chk("basic_marker", 8'(marker_err_a), 8'h0);
    chk("basic_busy", 8'(in_ready_a), 8'h0);
    step(); beat_a("basic1", 8'h3C, 1'b0);
    step(); beat_a("basic2", 8'h0F, 1'b0);
    step(); beat_a("basic3", 8'hF3, 1'b0);
    step(); beat_a("basic4", 8'h65, 1'b1);
    chk("basic_last_ready", 8'(in_ready_a), 8'h1);
    step();
    chk("basic_end_valid", 8'(out_valid_a), 8'h0);
    chk("basic_count", frame_count_a, 8'd1);
    chk("basic_marker_end", 8'(marker_err_a), 8'h0);

    // bad trailer, inputs change after accept
    a4 = 8'hF0;
    in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    a1 = 8'h00; a2 = 8'h00; a3 = 8'h00; a4 = 8'h00;
    chk("mk_pulse", 8'(marker_err_a), 8'h1);
    beat_a("mk0", 8'hA5, 1'b0);
    step();
    chk("mk_pulse_end", 8'(marker_err_a), 8'h0);
    beat_a("mk1", 8'h3C, 1'b0);
    step(); beat_a("mk2", 8'h0F, 1'b0);
    step(); beat_a("mk3", 8'hF0, 1'b0);
    step(); beat_a("mk4", 8'h66, 1'b1);
    step();
    chk("mk_count", frame_count_a, 8'd2);

    // backpressure on beat 1
    a1 = 8'hA5; a2 = 8'h3C; a3 = 8'h0F; a4 = 8'hF3;
    in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    beat_a("bp0", 8'hA5, 1'b0);
    step();
    beat_a("bp1", 8'h3C, 1'b0);
    out_ready_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      beat_a("bp_stall", 8'h3C, 1'b0);
    end
    out_ready_a = 1'b1;
    step(); beat_a("bp2", 8'h0F, 1'b0);
    step(); beat_a("bp3", 8'hF3, 1'b0);
    step(); beat_a("bp4", 8'h65, 1'b1);
    step();
    chk("bp_end_valid", 8'(out_valid_a), 8'h0);
    chk("bp_count", frame_count_a, 8'd3);

    // back-to-back, no checksum
    b1 = 8'h11; b2 = 8'h22; b3 = 8'h33; b4 = 8'h47;
    in_valid_b = 1'b1;
    step();
    b1 = 8'h55; b2 = 8'h66; b3 = 8'h77; b4 = 8'h8B;
    beat_b("b2b0", 8'h11, 1'b0);
    chk("b2b_busy", 8'(in_ready_b), 8'h0);
    step(); beat_b("b2b1", 8'h22, 1'b0);
    step(); beat_b("b2b2", 8'h33, 1'b0);
    step(); beat_b("b2b3", 8'h47, 1'b1);
    chk("b2b_last_ready", 8'(in_ready_b), 8'h1);
    step();
    in_valid_b = 1'b0;
    beat_b("b2b4", 8'h55, 1'b0);
    chk("b2b_count1", frame_count_b, 8'd1);
    step(); beat_b("b2b5", 8'h66, 1'b0);
    step(); beat_b("b2b6", 8'h77, 1'b0);
    step(); beat_b("b2b7", 8'h8B, 1'b1);
    step();
    chk("b2b_end_valid", 8'(out_valid_b), 8'h0);
    chk("b2b_count2", frame_count_b, 8'd2);
    chk("b2b_marker", 8'(marker_err_b), 8'h0);

    // reset during beat 2
    in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    step();
    step();
    beat_a("mr2", 8'h0F, 1'b0);
    reset = 1'b1;
    #1;
    chk("mr_ready_in_rst", 8'(in_ready_a), 8'h0);
    step();
    chk("mr_valid", 8'(out_valid_a), 8'h0);
    chk("mr_count", frame_count_a, 8'd0);
    reset = 1'b0;
    #1;
    chk("mr_ready_after", 8'(in_ready_a), 8'h1);

    // frame counter wrap
    for (int i = 0; i < 255; i++) send_frame_a();
    chk("wrap_255", frame_count_a, 8'd255);
    send_frame_a();
    chk("wrap_0", frame_count_a, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
# byte_serializer

- Downstream stage of the 30-bit field packer.
- Takes the four packed bytes (the six 5-bit fields plus the `2'b11` trailer, split high-to-low into `in_1`..`in_4`) as one parallel word.
- Emits the word one byte per cycle on a valid/ready stream, optionally followed by an XOR checksum byte.
- Flags words whose trailer bits are wrong and counts frames sent.

## Interface

Parameters:

- `BYTE_W`, 8, width of each byte lane and of `out_data`.
- `CHECKSUM_EN`, 1, when 1 a fifth beat carrying `in_1^in_2^in_3^in_4` follows the data bytes; when 0 the frame is 4 beats.

Ports:

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  parallel word present.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_1`..`in_4`  in  `BYTE_W` each  packed bytes; `in_1` is the most significant and is sent first.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer takes the beat this cycle.
- `out_data`  out  `BYTE_W`  current byte.
- `out_last`  out  1  current beat is the final beat of the frame.
- `marker_err`  out  1  one-cycle pulse: the accepted word had `in_4[1:0] != 2'b11`.
- `frame_count`  out  8  frames fully sent; wraps 255 -> 0.

## Operation

- **States:**
  - IDLE: nothing held.
  - SEND: a beat index 0..3 selects the byte latched from `in_1`..`in_4`.
  - CSUM: only when `CHECKSUM_EN`=1.
- **Accept:**
  - Handshake `in_valid && in_ready` latches all four bytes and the checksum into a holding register.
  - The block moves to SEND with index 0.
- **`in_ready`:**
  - High in IDLE.
  - Also high on the cycle the final beat is taken (`out_valid && out_ready && out_last`). This gives back-to-back frames with no bubble.
  - Low otherwise, and low while `reset` is high.
- **Beat advance:** occurs only on `out_valid && out_ready`.
  - SEND index 0..2 -> index+1.
  - Index 3 -> CSUM when `CHECKSUM_EN`=1; otherwise end of frame.
  - CSUM -> end of frame.
- **End of frame:**
  - `frame_count` increments.
  - Next state is SEND index 0 if a new word is accepted in the same cycle, else IDLE.
- **Backpressure:** while `out_valid && !out_ready`, `out_data` and `out_last` hold stable.
- **`out_last`:** high on index 3 when `CHECKSUM_EN`=0; high on CSUM when `CHECKSUM_EN`=1.
- **`marker_err`:**
  - Registered; pulses the cycle after an accept whose `in_4[1:0] != 2'b11`.
  - The frame is still sent unchanged.
- **Checksum:** bitwise XOR, `BYTE_W` wide, no carry; computed from the latched bytes.
- **Changing inputs:** `in_1`..`in_4` changing after accept has no effect on the frame in flight.

## Timing

- **Reset:** state IDLE, `out_valid`=0, `out_data`=0, `out_last`=0, `marker_err`=0, `frame_count`=0.
- **Reset mid-frame:** the frame is dropped and the count is not incremented.
- **Latency:** first beat is on `out_valid` the cycle after the accept edge.
- **Throughput:** with `out_ready` held high, a frame occupies 4 cycles (or 5 with checksum), and the next frame's first beat follows immediately.
- **Registered outputs:** `out_valid`, `out_data`, `out_last`, `marker_err`, `frame_count`.
- **Combinational output:** `in_ready` only, from state and `out_ready`.
- **Simultaneous events:**
  - Final-beat take plus new accept in the same cycle: the new frame's beat 0 is presented next cycle and `frame_count` increments once.
  - `reset` has priority over every handshake.

## Structure

- Package `byte_ser_pkg`:
  - state enum IDLE/SEND/CSUM;
  - beat index type (2 bits);
  - constant `TRAILER = 2'b11`.
- Single module with no sub-module. The holding register, FSM, index counter and frame counter sit together.

## Test plan

- **Basic frame, checksum on:**
  - Stimulus: after reset, accept `A5,3C,0F,F3` with `out_ready`=1.
  - Response: beats `A5,3C,0F,F3,65`; `out_last` only on `65`; `marker_err` stays 0; `frame_count`=1.
- **Marker error:**
  - Stimulus: accept `A5,3C,0F,F0`.
  - Response: `marker_err` pulses exactly one cycle after the accept; beats `A5,3C,0F,F0,66` are still sent.
- **Backpressure:**
  - Stimulus: drop `out_ready` for 3 cycles during beat 1 of the basic frame.
  - Response: `out_data` holds `3C` with `out_valid`=1 for all stalled cycles; no beat is lost or duplicated.
- **Back-to-back:**
  - Stimulus: hold `in_valid` with two words, `CHECKSUM_EN`=0.
  - Response: 8 consecutive beats with no bubble; `in_ready` high on the last-beat cycle; `frame_count`=2.
- **Reset mid-frame:**
  - Stimulus: assert `reset` during beat 2.
  - Response: next cycle `out_valid`=0, `frame_count` unchanged at its reset value 0, and `in_ready`=1 after release.
- **Counter wrap:**
  - Stimulus: send 256 frames.
  - Response: `frame_count` reads 255, then 0.
